// File: rtl/tff_meas_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tff_meas_pkg                                               |
// | Description : Shared types and helpers for the T_FF edge-rate counter.   |
// |               Holds the measurement FSM state encoding and the width     |
// |               helper used to size the window counter.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package tff_meas_pkg;

    // Measurement FSM encoding. The value 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Number of bits needed to hold values 0 .. value-1 (never less than 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage : tff_meas_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_edge_det                                              |
// | Description : Multi-flop synchroniser followed by a rising-edge          |
// |               detector. The detector runs continuously; gating is up to  |
// |               the consumer.                                              |
// | Ports       : clk       - clock, rising edge                             |
// |               reset     - asynchronous, active-low                       |
// |               d_async   - input that may be asynchronous to clk          |
// |               rise_edge - one-cycle pulse on a synchronised 0->1         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic rise_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_async};
            r_s_d  <= w_s;
        end
    end

    // History clears to 0, so an input already high at reset release
    // produces exactly one edge once it has crossed the synchroniser.
    assign rise_edge = w_s & ~r_s_d;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/tff_edge_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tff_edge_counter                                           |
// | Description : Counts synchronised rising edges of a T_FF output over     |
// |               fixed windows of WINDOW clk cycles and hands each result   |
// |               out on a valid/ready interface.                            |
// | Ports       : clk          - clock, rising edge                          |
// |               reset        - asynchronous, active-low                    |
// |               t_in         - T_FF q, may be asynchronous to clk          |
// |               enable       - run windows back to back                    |
// |               count_out    - edges in the last window (saturating)       |
// |               count_valid  - result valid, held until accepted           |
// |               count_ready  - consumer accepts on valid & ready           |
// |               overflow     - last window saturated                       |
// |               busy         - a window is being counted                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tff_edge_counter
    import tff_meas_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int WINDOW      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             enable,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             overflow,
    output logic             busy
);

    localparam int               c_CTR_W = clog2(WINDOW);
    localparam logic [c_CTR_W-1:0] c_LAST = c_CTR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] c_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   c_ONE   = {{CNT_W{1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CTR_W-1:0] r_ctr;
    // One spare bit: once the MSB is set the count has passed 2**CNT_W-1
    // and is frozen, so the value never wraps.
    logic [CNT_W:0]     r_count;
    logic [CNT_W:0]     w_next_count;
    logic [CNT_W-1:0]   r_count_out;
    logic               r_count_valid;
    logic               r_overflow;
    logic               w_edge;
    logic               w_last;
    logic               w_accept;
    logic               w_busy;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk       (clk),
        .reset     (reset),
        .d_async   (t_in),
        .rise_edge (w_edge)
    );

    assign w_last   = (r_ctr == c_LAST);
    assign w_accept = r_count_valid & count_ready;

    always_comb begin
        w_next_count = r_count;
        if (!r_count[CNT_W] && w_edge) begin
            w_next_count = r_count + c_ONE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status decode
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_next = COUNT;
                end
            end
            COUNT: begin
                w_busy = 1'b1;
                if (!enable) begin
                    w_state_next = IDLE;
                end else if (w_last) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                // A pending result survives enable=0; only the handshake
                // releases HOLD.
                if (w_accept) begin
                    w_state_next = enable ? COUNT : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Window counter, edge counter and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctr         <= '0;
            r_count       <= '0;
            r_count_out   <= '0;
            r_count_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (r_state == COUNT && enable) begin
                r_ctr   <= r_ctr + c_CTR_W'(1);
                r_count <= w_next_count;
                if (w_last) begin
                    // The edge seen on the final window cycle is included.
                    r_count_out   <= w_next_count[CNT_W] ? c_MAX : w_next_count[CNT_W-1:0];
                    r_overflow    <= w_next_count[CNT_W];
                    r_count_valid <= 1'b1;
                end
            end else begin
                // Outside an active window the counters sit at zero so the
                // next window always starts clean; an aborted window is lost.
                r_ctr   <= '0;
                r_count <= '0;
            end

            if (r_state == HOLD && w_accept) begin
                r_count_valid <= 1'b0;
            end
        end
    end

    assign count_out   = r_count_out;
    assign count_valid = r_count_valid;
    assign overflow    = r_overflow;
    assign busy        = w_busy;

endmodule : tff_edge_counter
`default_nettype wire
